bidsn_engine: RTL and testbench
===============================

# bidsn_engine

Parametrised N-bidder sealed-bid auction engine; successor to the fixed three-bidder X/Y/Z auction block. Holds per-bidder balances, a participation mask and a per-bid fee. Accepts bids and retracts while a round is open and resolves the winner with lowest-index tie-break. It sits behind the same control-op bus (op/data) that the testbench and system controller drive, with a key-protected lock and an optional brute-force lockout.

## Interface
- N_BIDDERS, 4: number of bidders (2..8).
- AMT_W, 16: bid amount width.
- BAL_W, 32: balance and max_bid width; must be ≥ AMT_W+1.
- MAX_FAILS, 3: consecutive bad unlocks before lockout.
- COOLDOWN_CYC, 16: lockout length in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- bid  in  N_BIDDERS  per-bidder bid strobe.
- retract  in  N_BIDDERS  per-bidder retract strobe.
- bid_amt  in  N_BIDDERS*AMT_W  bidder i at [i*AMT_W +: AMT_W].
- c_start  in  1  round open while high.
- c_op  in  4  0 nop, 1 unlock, 2 lock, 3 write balance, 4 set mask, 5 set fee, 7 select bidder.
- c_data  in  32  op operand.
- ack  out  N_BIDDERS  1-cycle accept pulse.
- err  out  2*N_BIDDERS  per-bidder code: 00 ok, 01 insufficient funds, 10 not accepting, 11 retract with no bid.
- win  out  N_BIDDERS  1-cycle winner pulse.
- ready  out  1  high only in IDLE.
- round_over  out  1  1-cycle pulse in RESOLVE.
- ctl_err  out  3  000 ok, 001 bad key, 010 op illegal in state, 011 c_start while unlocked, 100 lockout active, 101 index ≥ N_BIDDERS.
- balance  out  N_BIDDERS*BAL_W  current balances.
- max_bid  out  BAL_W  last winning amount, zero-extended.

## Operation
- States: UNLOCKED → (op 2) IDLE → (c_start=1) ROUND → (c_start=0) RESOLVE → IDLE. Op 1 with key match in IDLE → UNLOCKED.
- Lock (op 2) stores c_data as key. Unlock (op 1) compares c_data with key; mismatch gives ctl_err=001 and increments the fail counter. A match clears the counter.
- Ops 3/4/5/7 are legal only in UNLOCKED; otherwise ctl_err=010 and the op has no effect.
  - Op 7 latches index c_data[2:0]; out of range gives 101 and the index is unchanged.
  - Op 3 writes balance[index] = c_data[BAL_W-1:0].
  - Op 4 sets mask = c_data[N_BIDDERS-1:0].
  - Op 5 sets fee = c_data[AMT_W-1:0].
- Op 1/2 in ROUND/RESOLVE gives 010. c_start high in UNLOCKED gives 011.
- Entering ROUND clears all held bids.
- Bid i is accepted only in ROUND with c_start=1 and mask[i]=1, else err 10. It also needs amt+fee ≤ balance[i] (computed at BAL_W+1 bits), else err 01.
  - On accept: ack[i]=1, balance[i] -= fee, held bid replaced by amt. Zero amount is legal.
- Retract i in ROUND with c_start=1 clears the held bid and gives ack[i]. With no held bid it gives err 11, with no fee refund.
  - Retract and bid from the same bidder in the same cycle: retract wins, bid ignored.
- RESOLVE: the highest held amount wins, ties go to the lowest index. win[w]=1, balance[w] -= amt, max_bid=amt. With no held bids: no win, max_bid=0, round_over still pulses.

## Timing
- Reset value: all outputs 0, balances 0, mask all-ones, fee 0, key 0, fail counter 0, state UNLOCKED.
- All outputs are registered. ack/err/ctl_err appear the cycle after the sampling edge and are valid for 1 cycle.
- c_start sampled high in IDLE at edge k → ROUND after k. Bids are accepted from edge k+1.
- Edge j in ROUND with c_start=0 → RESOLVE; bids at j get err 10. win/round_over/max_bid/balance update at edge j+1, and the block is in IDLE (ready=1) after edge j+2.
- Asserting reset mid-round discards bids and restores reset values immediately.

## Configuration
- BIDSN_LOCKOUT_EN defined:
  - MAX_FAILS consecutive bad unlocks start a COOLDOWN_CYC-cycle lockout.
  - During lockout every unlock, even with the correct key, gives ctl_err=100 and does not count as a fail.
  - The counter clears when the lockout expires.
- Not defined: no counter and no lockout; bad unlocks only report 001.

## Test plan
- Reset, op3 idx0=0x100, idx1=0x100, fee 2, lock key 0xA5 → ready=1, ctl_err=000 throughout.
- Round: X bids 0x50, Y bids 0x50 same cycle, c_start drops → win[0]=1, balance0=0x100-2-0x50=0xAE, balance1=0xFE, max_bid=0x50.
- Balance 0x10, fee 2, bid 0xF → err 01, balance unchanged. Bid 0xE → ack, balance 0x0E.
- mask=0b0010, bidder 0 bids → err 10. Retract on bidder 1 with no bid → err 11. Simultaneous bid+retract → only retract effect.
- BIDSN_LOCKOUT_EN: three unlocks with 0x00 → 001 ×3. Correct key next cycle → 100. After 16 cycles correct key → UNLOCKED, ready=0.
- Reset asserted two cycles into a round with held bids → all outputs 0, state UNLOCKED, no win pulse.

Source files
------------

// File: rtl/bidsn_engine.sv
// bidsn_engine -- N-bidder sealed-bid auction engine.
//
// Holds per-bidder balances, a participation mask and a per-bid fee. Bids
// and retracts are taken while a round is open. The round resolves to the
// highest held bid, with ties going to the lowest bidder index. Configuration
// goes through a key-protected op bus (c_op/c_data).
//
// Optional feature: define BIDSN_LOCKOUT_EN to enable the brute-force
// unlock lockout (MAX_FAILS consecutive bad keys -> COOLDOWN_CYC-cycle lockout).
//
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   bid, retract      per-bidder strobes
//   bid_amt           bidder i amount at [i*AMT_W +: AMT_W]
//   c_start           round open while high
//   c_op, c_data      control op and operand
//   ack, err          per-bidder accept pulse / 2-bit error code
//   win, round_over   winner pulse / end-of-round pulse
//   ready             high in IDLE
//   ctl_err           control-op status code
//   balance           packed per-bidder balances
//   max_bid           last winning amount, zero-extended
module bidsn_engine #(
  parameter int N_BIDDERS    = 4,
  parameter int AMT_W        = 16,
  parameter int BAL_W        = 32,
  parameter int MAX_FAILS    = 3,
  parameter int COOLDOWN_CYC = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BIDDERS-1:0]         bid,
  input  logic [N_BIDDERS-1:0]         retract,
  input  logic [N_BIDDERS*AMT_W-1:0]   bid_amt,
  input  logic                         c_start,
  input  logic [3:0]                   c_op,
  input  logic [31:0]                  c_data,
  output logic [N_BIDDERS-1:0]         ack,
  output logic [2*N_BIDDERS-1:0]       err,
  output logic [N_BIDDERS-1:0]         win,
  output logic                         ready,
  output logic                         round_over,
  output logic [2:0]                   ctl_err,
  output logic [N_BIDDERS*BAL_W-1:0]   balance,
  output logic [BAL_W-1:0]             max_bid
);

  if (N_BIDDERS < 2 || N_BIDDERS > 8 || BAL_W < AMT_W + 1 ||
      MAX_FAILS < 1 || COOLDOWN_CYC < 1) begin : g_param_check
    $error("bidsn_engine: illegal parameter set");
  end

  localparam logic [3:0] OP_UNLOCK = 4'd1;
  localparam logic [3:0] OP_LOCK   = 4'd2;
  localparam logic [3:0] OP_WBAL   = 4'd3;
  localparam logic [3:0] OP_MASK   = 4'd4;
  localparam logic [3:0] OP_FEE    = 4'd5;
  localparam logic [3:0] OP_SEL    = 4'd7;

  typedef enum logic [1:0] {S_UNLOCKED, S_IDLE, S_ROUND, S_RESOLVE} state_t;
  typedef enum logic [2:0] {CE_OK, CE_BADKEY, CE_ILLEGAL, CE_CSTART,
                            CE_LOCKOUT, CE_INDEX} ctl_code_t;
  typedef enum logic [1:0] {BE_OK, BE_FUNDS, BE_CLOSED, BE_NOBID} bid_code_t;

  state_t                 r_state;
  logic [BAL_W-1:0]       r_bal [N_BIDDERS];
  logic [AMT_W-1:0]       r_held [N_BIDDERS];
  logic [N_BIDDERS-1:0]   r_held_v;
  logic [N_BIDDERS-1:0]   r_mask;
  logic [AMT_W-1:0]       r_fee;
  logic [31:0]            r_key;
  logic [2:0]             r_idx;

  logic [N_BIDDERS-1:0]   r_ack;
  logic [2*N_BIDDERS-1:0] r_err;
  logic [N_BIDDERS-1:0]   r_win;
  logic                   r_ready;
  logic                   r_round_over;
  logic [2:0]             r_ctl_err;
  logic [BAL_W-1:0]       r_max_bid;

`ifdef BIDSN_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int COOL_W = $clog2(COOLDOWN_CYC + 1);
  logic [FAIL_W-1:0]      r_fails;
  logic [COOL_W-1:0]      r_cool;
`endif

  logic                   w_lockout;
  logic                   w_accepting;
  logic                   w_in_round;
  logic [N_BIDDERS-1:0]   w_afford;
  logic                   w_found;
  logic [2:0]             w_win_idx;
  logic [AMT_W-1:0]       w_win_amt;
  ctl_code_t              w_ctl_code;
  logic                   w_unlock_ok, w_unlock_bad, w_lock;
  logic                   w_sel, w_wbal, w_wmask, w_wfee;

`ifdef BIDSN_LOCKOUT_EN
  assign w_lockout = (r_cool != '0);
`else
  assign w_lockout = 1'b0;
`endif

  assign w_accepting = (r_state == S_ROUND) && c_start;
  assign w_in_round  = (r_state == S_ROUND) || (r_state == S_RESOLVE);

  // Funds check at BAL_W+1 bits so amt+fee cannot wrap.
  always_comb begin
    w_afford = '0;
    for (int unsigned i = 0; i < N_BIDDERS; i++) begin
      w_afford[i] = ((BAL_W+1)'(bid_amt[i*AMT_W +: AMT_W]) + (BAL_W+1)'(r_fee))
                    <= (BAL_W+1)'(r_bal[i]);
    end
  end

  // Strict '>' during the ascending scan keeps the lowest index on ties.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_win_amt = '0;
    for (int unsigned i = 0; i < N_BIDDERS; i++) begin
      if (r_held_v[i] && (!w_found || r_held[i] > w_win_amt)) begin
        w_found   = 1'b1;
        w_win_idx = 3'(i);
        w_win_amt = r_held[i];
      end
    end
  end

  always_comb begin
    w_ctl_code   = CE_OK;
    w_unlock_ok  = 1'b0;
    w_unlock_bad = 1'b0;
    w_lock       = 1'b0;
    w_sel        = 1'b0;
    w_wbal       = 1'b0;
    w_wmask      = 1'b0;
    w_wfee       = 1'b0;
    case (c_op)
      OP_UNLOCK: begin
        if (w_in_round)          w_ctl_code = CE_ILLEGAL;
        else if (w_lockout)      w_ctl_code = CE_LOCKOUT;
        else if (c_data == r_key) w_unlock_ok = 1'b1;
        else begin
          w_ctl_code   = CE_BADKEY;
          w_unlock_bad = 1'b1;
        end
      end
      OP_LOCK: begin
        if (w_in_round) w_ctl_code = CE_ILLEGAL;
        else            w_lock     = 1'b1;
      end
      OP_WBAL: begin
        if (r_state != S_UNLOCKED) w_ctl_code = CE_ILLEGAL;
        else                       w_wbal     = 1'b1;
      end
      OP_MASK: begin
        if (r_state != S_UNLOCKED) w_ctl_code = CE_ILLEGAL;
        else                       w_wmask    = 1'b1;
      end
      OP_FEE: begin
        if (r_state != S_UNLOCKED) w_ctl_code = CE_ILLEGAL;
        else                       w_wfee     = 1'b1;
      end
      OP_SEL: begin
        if (r_state != S_UNLOCKED)                 w_ctl_code = CE_ILLEGAL;
        else if (c_data[2:0] > 3'(N_BIDDERS - 1))  w_ctl_code = CE_INDEX;
        else                                       w_sel      = 1'b1;
      end
      default: ;
    endcase
    if (w_ctl_code == CE_OK && r_state == S_UNLOCKED && c_start)
      w_ctl_code = CE_CSTART;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_UNLOCKED;
      for (int unsigned i = 0; i < N_BIDDERS; i++) begin
        r_bal[i]  <= '0;
        r_held[i] <= '0;
      end
      r_held_v     <= '0;
      r_mask       <= '1;
      r_fee        <= '0;
      r_key        <= '0;
      r_idx        <= '0;
      r_ack        <= '0;
      r_err        <= '0;
      r_win        <= '0;
      r_ready      <= 1'b0;
      r_round_over <= 1'b0;
      r_ctl_err    <= '0;
      r_max_bid    <= '0;
`ifdef BIDSN_LOCKOUT_EN
      r_fails      <= '0;
      r_cool       <= '0;
`endif
    end else begin
      r_ack        <= '0;
      r_err        <= '0;
      r_win        <= '0;
      r_round_over <= 1'b0;
      r_ctl_err    <= w_ctl_code;
      // ready follows the state of the previous cycle.
      r_ready      <= (r_state == S_IDLE);

      if (w_sel)   r_idx  <= c_data[2:0];
      if (w_wmask) r_mask <= c_data[N_BIDDERS-1:0];
      if (w_wfee)  r_fee  <= AMT_W'(c_data);
      if (w_lock)  r_key  <= c_data;

      case (r_state)
        S_UNLOCKED: if (w_lock) r_state <= S_IDLE;
        S_IDLE: begin
          if (w_unlock_ok) r_state <= S_UNLOCKED;
          else if (c_start) begin
            r_state  <= S_ROUND;
            r_held_v <= '0;
          end
        end
        S_ROUND: if (!c_start) r_state <= S_RESOLVE;
        S_RESOLVE: begin
          r_round_over <= 1'b1;
          r_max_bid    <= w_found ? BAL_W'(w_win_amt) : '0;
          r_held_v     <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_UNLOCKED;
      endcase

      for (int unsigned i = 0; i < N_BIDDERS; i++) begin
        if (w_accepting) begin
          if (retract[i]) begin
            if (r_held_v[i]) begin
              r_held_v[i] <= 1'b0;
              r_ack[i]    <= 1'b1;
            end else begin
              r_err[2*i +: 2] <= BE_NOBID;
            end
          end else if (bid[i]) begin
            if (!r_mask[i])        r_err[2*i +: 2] <= BE_CLOSED;
            else if (!w_afford[i]) r_err[2*i +: 2] <= BE_FUNDS;
            else begin
              r_ack[i]    <= 1'b1;
              r_bal[i]    <= r_bal[i] - BAL_W'(r_fee);
              r_held[i]   <= bid_amt[i*AMT_W +: AMT_W];
              r_held_v[i] <= 1'b1;
            end
          end
        end else if (bid[i] || retract[i]) begin
          r_err[2*i +: 2] <= BE_CLOSED;
        end
        if (w_wbal && r_idx == 3'(i))
          r_bal[i] <= BAL_W'(c_data);
        if (r_state == S_RESOLVE && w_found && w_win_idx == 3'(i)) begin
          r_win[i] <= 1'b1;
          r_bal[i] <= r_bal[i] - BAL_W'(r_held[i]);
        end
      end

`ifdef BIDSN_LOCKOUT_EN
      if (r_cool != '0) begin
        r_cool <= r_cool - COOL_W'(1);
        if (r_cool == COOL_W'(1)) r_fails <= '0;
      end else if (w_unlock_bad) begin
        if (r_fails == FAIL_W'(MAX_FAILS - 1)) r_cool <= COOL_W'(COOLDOWN_CYC);
        r_fails <= r_fails + FAIL_W'(1);
      end else if (w_unlock_ok) begin
        r_fails <= '0;
      end
`endif
    end
  end

  assign ack        = r_ack;
  assign err        = r_err;
  assign win        = r_win;
  assign ready      = r_ready;
  assign round_over = r_round_over;
  assign ctl_err    = r_ctl_err;
  assign max_bid    = r_max_bid;

  for (genvar g = 0; g < N_BIDDERS; g++) begin : g_bal
    assign balance[g*BAL_W +: BAL_W] = r_bal[g];
  end

endmodule

// File: tb/tb_bidsn_engine.sv
// Self-checking bench for bidsn_engine with a behavioural auction model.
module tb_bidsn_engine;
  localparam int N = 4;
  localparam int AMT_W = 16;
  localparam int BAL_W = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         bid, retract;
  logic [N*AMT_W-1:0]   bid_amt;
  logic                 c_start;
  logic [3:0]           c_op;
  logic [31:0]          c_data;
  logic [N-1:0]         ack;
  logic [2*N-1:0]       err;
  logic [N-1:0]         win;
  logic                 ready;
  logic                 round_over;
  logic [2:0]           ctl_err;
  logic [N*BAL_W-1:0]   balance;
  logic [BAL_W-1:0]     max_bid;

  int n_tests = 0;
  int n_fail  = 0;

  longint       m_bal [N];
  int           m_held[N];
  logic [N-1:0] m_mask;
  longint       m_fee;
  logic [31:0]  m_key;
  int           m_idx;

  bidsn_engine #(.N_BIDDERS(N), .AMT_W(AMT_W), .BAL_W(BAL_W),
                 .MAX_FAILS(3), .COOLDOWN_CYC(16)) dut (
    .clk(clk), .reset(reset), .bid(bid), .retract(retract), .bid_amt(bid_amt),
    .c_start(c_start), .c_op(c_op), .c_data(c_data), .ack(ack), .err(err),
    .win(win), .ready(ready), .round_over(round_over), .ctl_err(ctl_err),
    .balance(balance), .max_bid(max_bid));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] d, output logic [2:0] ce);
    c_op = op; c_data = d;
    step();
    ce = ctl_err;
    c_op = 4'd0; c_data = '0;
  endtask

  function automatic logic [N*BAL_W-1:0] exp_bal();
    logic [N*BAL_W-1:0] v;
    for (int i = 0; i < N; i++) v[i*BAL_W +: BAL_W] = BAL_W'(m_bal[i]);
    return v;
  endfunction

  task automatic clear_bids();
    bid = '0; retract = '0; bid_amt = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; c_start = 1'b0; c_op = '0; c_data = '0; clear_bids();
    step(); step();
    n_tests++; if (ack !== '0) begin n_fail++; $display("FAIL rst_ack got %b exp 0", ack); end
    n_tests++; if (err !== '0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err); end
    n_tests++; if (win !== '0 || round_over !== 1'b0) begin n_fail++; $display("FAIL rst_win got %b/%b exp 0/0", win, round_over); end
    n_tests++; if (ready !== 1'b0 || ctl_err !== 3'b000) begin n_fail++; $display("FAIL rst_ctl got %b/%b exp 0/000", ready, ctl_err); end
    n_tests++; if (balance !== '0 || max_bid !== '0) begin n_fail++; $display("FAIL rst_bal got %h/%h exp 0/0", balance, max_bid); end
    reset = 1'b0;
    step();
    n_tests++; if (ready !== 1'b0 || ctl_err !== 3'b000) begin n_fail++; $display("FAIL rst_release got %b/%b exp 0/000", ready, ctl_err); end
    for (int i = 0; i < N; i++) begin m_bal[i] = 0; m_held[i] = -1; end
    m_mask = '1; m_fee = 0; m_key = '0; m_idx = 0;
  endtask

  task automatic test_setup();
    logic [2:0] ce;
    logic [3:0] ops[10];
    logic [31:0] ds[10];
    m_bal[2] = $urandom_range(0, 'h200);
    m_bal[3] = $urandom_range(0, 'h200);
    ops = '{4'd7, 4'd3, 4'd7, 4'd3, 4'd7, 4'd3, 4'd7, 4'd3, 4'd5, 4'd2};
    ds  = '{32'd0, 32'h100, 32'd1, 32'h100, 32'd2, 32'(m_bal[2]), 32'd3, 32'(m_bal[3]), 32'd2, 32'hA5};
    for (int k = 0; k < 10; k++) begin
      do_op(ops[k], ds[k], ce);
      n_tests++; if (ce !== 3'b000) begin n_fail++; $display("FAIL setup_op%0d got %b exp 000", k, ce); end
    end
    m_bal[0] = 'h100; m_bal[1] = 'h100; m_fee = 2; m_key = 32'hA5; m_idx = 3;
    step();
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL setup_ready got %b exp 1", ready); end
    n_tests++; if (balance !== exp_bal()) begin n_fail++; $display("FAIL setup_bal got %h exp %h", balance, exp_bal()); end
  endtask

  task automatic test_round_tie();
    logic [2*N-1:0] e;
    c_start = 1'b1; bid[2] = 1'b1; bid_amt[2*AMT_W +: AMT_W] = 16'h10;
    step();
    e = '0; e[5:4] = 2'b10;
    n_tests++; if (err !== e || ack !== '0) begin n_fail++; $display("FAIL tie_open_edge got err %b ack %b exp %b 0", err, ack, e); end
    clear_bids();
    bid[0] = 1'b1; bid[1] = 1'b1;
    bid_amt[0 +: AMT_W] = 16'h50; bid_amt[AMT_W +: AMT_W] = 16'h50;
    step();
    n_tests++; if (ack !== 4'b0011 || err !== '0) begin n_fail++; $display("FAIL tie_ack got %b/%b exp 0011/0", ack, err); end
    clear_bids(); c_start = 1'b0; bid[3] = 1'b1;
    step();
    e = '0; e[7:6] = 2'b10;
    n_tests++; if (err !== e || ack !== '0) begin n_fail++; $display("FAIL tie_close_edge got err %b ack %b exp %b 0", err, ack, e); end
    clear_bids();
    step();
    m_bal[0] = 'hAE; m_bal[1] = 'hFE;
    n_tests++; if (win !== 4'b0001 || round_over !== 1'b1) begin n_fail++; $display("FAIL tie_win got %b/%b exp 0001/1", win, round_over); end
    n_tests++; if (max_bid !== 32'h50) begin n_fail++; $display("FAIL tie_max got %h exp 50", max_bid); end
    n_tests++; if (balance !== exp_bal()) begin n_fail++; $display("FAIL tie_bal got %h exp %h", balance, exp_bal()); end
    step();
    n_tests++; if (ready !== 1'b1 || win !== '0 || round_over !== 1'b0) begin n_fail++; $display("FAIL tie_idle got %b/%b/%b exp 1/0/0", ready, win, round_over); end
  endtask

  task automatic test_funds();
    logic [2:0] ce;
    do_op(4'd1, m_key, ce);
    n_tests++; if (ce !== 3'b000) begin n_fail++; $display("FAIL funds_unlock got %b exp 000", ce); end
    do_op(4'd7, 32'd0, ce); do_op(4'd3, 32'h10, ce); do_op(4'd5, 32'd2, ce); do_op(4'd2, m_key, ce);
    m_bal[0] = 'h10; m_fee = 2; m_idx = 0;
    c_start = 1'b1; step();
    bid[0] = 1'b1; bid_amt[0 +: AMT_W] = 16'hF;
    step();
    n_tests++; if (err[1:0] !== 2'b01 || ack !== '0) begin n_fail++; $display("FAIL funds_short got %b/%b exp 01/0", err[1:0], ack); end
    n_tests++; if (balance !== exp_bal()) begin n_fail++; $display("FAIL funds_short_bal got %h exp %h", balance, exp_bal()); end
    bid_amt[0 +: AMT_W] = 16'hE;
    step();
    m_bal[0] = 'hE;
    n_tests++; if (ack !== 4'b0001 || err !== '0) begin n_fail++; $display("FAIL funds_exact got %b/%b exp 0001/0", ack, err); end
    n_tests++; if (balance !== exp_bal()) begin n_fail++; $display("FAIL funds_exact_bal got %h exp %h", balance, exp_bal()); end
    clear_bids(); c_start = 1'b0;
    step(); step();
    m_bal[0] = 0;
    n_tests++; if (win !== 4'b0001 || max_bid !== 32'hE || balance !== exp_bal()) begin n_fail++; $display("FAIL funds_win got %b/%h/%h exp 0001/e/%h", win, max_bid, balance, exp_bal()); end
    step();
  endtask

  task automatic test_mask_retract();
    logic [2:0] ce;
    do_op(4'd1, m_key, ce);
    do_op(4'd4, 32'b0010, ce); do_op(4'd7, 32'd1, ce); do_op(4'd3, 32'h40, ce);
    do_op(4'd2, m_key, ce);
    m_mask = 4'b0010; m_idx = 1; m_bal[1] = 'h40;
    c_start = 1'b1; step();
    bid[0] = 1'b1; bid_amt[0 +: AMT_W] = 16'h1; retract[1] = 1'b1;
    step();
    n_tests++; if (err !== 8'b0000_1110 || ack !== '0) begin n_fail++; $display("FAIL mask_nobid got %b/%b exp 00001110/0", err, ack); end
    clear_bids(); bid[1] = 1'b1; bid_amt[AMT_W +: AMT_W] = 16'h5;
    step();
    m_bal[1] = 'h3E;
    n_tests++; if (ack !== 4'b0010 || balance !== exp_bal()) begin n_fail++; $display("FAIL mask_bid1 got %b/%h exp 0010/%h", ack, balance, exp_bal()); end
    bid_amt[AMT_W +: AMT_W] = 16'h7; retract[1] = 1'b1;
    step();
    n_tests++; if (ack !== 4'b0010 || err !== '0 || balance !== exp_bal()) begin n_fail++; $display("FAIL bid_retract got %b/%b/%h exp 0010/0/%h", ack, err, balance, exp_bal()); end
    clear_bids(); c_start = 1'b0;
    step(); step();
    n_tests++; if (win !== '0 || round_over !== 1'b1 || max_bid !== '0) begin n_fail++; $display("FAIL empty_round got %b/%b/%h exp 0/1/0", win, round_over, max_bid); end
    step();
  endtask

  task automatic test_ctl_errors();
    logic [2:0] ce;
    do_op(4'd3, 32'h55, ce);
    n_tests++; if (ce !== 3'b010) begin n_fail++; $display("FAIL ctl_wbal_idle got %b exp 010", ce); end
    do_op(4'd7, 32'd0, ce);
    n_tests++; if (ce !== 3'b010) begin n_fail++; $display("FAIL ctl_sel_idle got %b exp 010", ce); end
    do_op(4'd1, m_key ^ 32'h1, ce);
    n_tests++; if (ce !== 3'b001) begin n_fail++; $display("FAIL ctl_badkey got %b exp 001", ce); end
    do_op(4'd1, m_key, ce);
    do_op(4'd7, 32'd5, ce);
    n_tests++; if (ce !== 3'b101) begin n_fail++; $display("FAIL ctl_index got %b exp 101", ce); end
    do_op(4'd3, 32'h77, ce);
    m_bal[m_idx] = 'h77;
    n_tests++; if (balance !== exp_bal()) begin n_fail++; $display("FAIL ctl_index_kept got %h exp %h", balance, exp_bal()); end
    c_start = 1'b1; step(); c_start = 1'b0;
    n_tests++; if (ctl_err !== 3'b011) begin n_fail++; $display("FAIL ctl_cstart got %b exp 011", ctl_err); end
    do_op(4'd2, m_key, ce);
    c_start = 1'b1; step();
    do_op(4'd1, m_key, ce);
    n_tests++; if (ce !== 3'b010) begin n_fail++; $display("FAIL ctl_unlock_round got %b exp 010", ce); end
    do_op(4'd2, 32'h1234, ce);
    n_tests++; if (ce !== 3'b010) begin n_fail++; $display("FAIL ctl_lock_round got %b exp 010", ce); end
    c_start = 1'b0; step(); step(); step();
  endtask

  task automatic test_random_rounds();
    logic [2:0] ce;
    logic [N-1:0] ea, ew;
    logic [2*N-1:0] ee;
    int amts[N];
    int ncyc, best, w;
    for (int r = 0; r < 16; r++) begin
      do_op(4'd1, m_key, ce);
      n_tests++; if (ce !== 3'b000) begin n_fail++; $display("FAIL rnd_unlock r=%0d got %b exp 000", r, ce); end
      m_mask = 4'($urandom_range(0, 15)); m_fee = $urandom_range(0, 8);
      do_op(4'd4, 32'(m_mask), ce); do_op(4'd5, 32'(m_fee), ce);
      for (int i = 0; i < N; i++) begin
        m_bal[i] = $urandom_range(0, 'h180);
        do_op(4'd7, 32'(i), ce); do_op(4'd3, 32'(m_bal[i]), ce);
      end
      m_idx = N - 1;
      m_key = $urandom | 32'h1;
      do_op(4'd2, m_key, ce);
      n_tests++; if (ce !== 3'b000) begin n_fail++; $display("FAIL rnd_lock r=%0d got %b exp 000", r, ce); end
      c_start = 1'b1; step();
      for (int i = 0; i < N; i++) m_held[i] = -1;
      ncyc = $urandom_range(1, 6);
      for (int c = 0; c < ncyc; c++) begin
        for (int i = 0; i < N; i++) begin
          int sel;
          sel = $urandom_range(0, 3);
          amts[i] = $urandom_range(0, 'h100);
          bid[i] = sel[0]; retract[i] = sel[1];
          bid_amt[i*AMT_W +: AMT_W] = 16'(amts[i]);
        end
        ea = '0; ee = '0;
        for (int i = 0; i < N; i++) begin
          if (retract[i]) begin
            if (m_held[i] >= 0) begin ea[i] = 1'b1; m_held[i] = -1; end
            else ee[2*i +: 2] = 2'b11;
          end else if (bid[i]) begin
            if (!m_mask[i]) ee[2*i +: 2] = 2'b10;
            else if (amts[i] + m_fee > m_bal[i]) ee[2*i +: 2] = 2'b01;
            else begin ea[i] = 1'b1; m_bal[i] -= m_fee; m_held[i] = amts[i]; end
          end
        end
        step();
        n_tests++; if (ack !== ea || err !== ee) begin n_fail++; $display("FAIL rnd_bid r=%0d c=%0d got %b/%b exp %b/%b", r, c, ack, err, ea, ee); end
      end
      clear_bids(); c_start = 1'b0;
      step();
      best = -1; w = -1;
      for (int i = 0; i < N; i++) if (m_held[i] > best) begin best = m_held[i]; w = i; end
      ew = '0;
      if (w >= 0) begin ew[w] = 1'b1; m_bal[w] -= best; end
      step();
      n_tests++; if (win !== ew || round_over !== 1'b1) begin n_fail++; $display("FAIL rnd_win r=%0d got %b/%b exp %b/1", r, win, round_over, ew); end
      n_tests++; if (max_bid !== BAL_W'((w >= 0) ? best : 0) || balance !== exp_bal()) begin n_fail++; $display("FAIL rnd_res r=%0d got %h/%h exp %0d/%h", r, max_bid, balance, best, exp_bal()); end
      step();
    end
  endtask

  task automatic test_lockout();
    logic [2:0] ce;
`ifdef BIDSN_LOCKOUT_EN
    for (int k = 0; k < 3; k++) begin
      do_op(4'd1, 32'h0, ce);
      n_tests++; if (ce !== 3'b001) begin n_fail++; $display("FAIL lk_bad%0d got %b exp 001", k, ce); end
    end
    do_op(4'd1, m_key, ce);
    n_tests++; if (ce !== 3'b100 || ready !== 1'b1) begin n_fail++; $display("FAIL lk_active got %b/%b exp 100/1", ce, ready); end
    do_op(4'd1, 32'h0, ce);
    n_tests++; if (ce !== 3'b100) begin n_fail++; $display("FAIL lk_active_bad got %b exp 100", ce); end
    repeat (7) step();
    do_op(4'd1, m_key, ce);
    n_tests++; if (ce !== 3'b100) begin n_fail++; $display("FAIL lk_mid got %b exp 100", ce); end
    repeat (9) step();
`else
    for (int k = 0; k < 5; k++) begin
      do_op(4'd1, 32'h0, ce);
      n_tests++; if (ce !== 3'b001) begin n_fail++; $display("FAIL nolk_bad%0d got %b exp 001", k, ce); end
    end
`endif
    do_op(4'd1, m_key, ce);
    n_tests++; if (ce !== 3'b000) begin n_fail++; $display("FAIL lk_unlock got %b exp 000", ce); end
    step();
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL lk_unlocked_ready got %b exp 0", ready); end
  endtask

  task automatic test_reset_mid_round();
    logic [2:0] ce;
    do_op(4'd4, 32'hF, ce); do_op(4'd5, 32'd1, ce);
    do_op(4'd7, 32'd0, ce); do_op(4'd3, 32'h100, ce);
    do_op(4'd7, 32'd1, ce); do_op(4'd3, 32'h100, ce);
    do_op(4'd2, m_key, ce);
    c_start = 1'b1; step();
    bid[0] = 1'b1; bid[1] = 1'b1;
    bid_amt[0 +: AMT_W] = 16'h20; bid_amt[AMT_W +: AMT_W] = 16'h30;
    step();
    n_tests++; if (ack !== 4'b0011) begin n_fail++; $display("FAIL mid_ack got %b exp 0011", ack); end
    clear_bids(); step();
    reset = 1'b1; c_start = 1'b0;
    #1;
    n_tests++; if (ack !== '0 || err !== '0 || win !== '0 || round_over !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pulse got %b/%b/%b/%b exp 0", ack, err, win, round_over); end
    n_tests++; if (ready !== 1'b0 || ctl_err !== '0 || balance !== '0 || max_bid !== '0) begin n_fail++; $display("FAIL mid_rst_state got %b/%b/%h/%h exp 0", ready, ctl_err, balance, max_bid); end
    step(); reset = 1'b0;
    step(); step();
    n_tests++; if (win !== '0 || round_over !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL mid_after got %b/%b/%b exp 0/0/0", win, round_over, ready); end
    c_start = 1'b1; step(); c_start = 1'b0;
    n_tests++; if (ctl_err !== 3'b011) begin n_fail++; $display("FAIL mid_unlocked got %b exp 011", ctl_err); end
  endtask

  initial begin
    test_reset();
    test_setup();
    test_round_tie();
    test_funds();
    test_mask_retract();
    test_ctl_errors();
    test_random_rounds();
    test_lockout();
    test_reset_mid_round();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
